// File: rtl/mem_arbiter_pkg.sv
// Shared constants, FSM state encodings and a range helper for the
// two-port memory arbiter.
package mem_arbiter_pkg;

  // Memory geometry, shared with the memory model.
  localparam int MEM_DEPTH  = 2048;  // bytes
  localparam int MEM_WIDTH  = 8;     // bits per byte cell
  localparam int WORD_WIDTH = 16;    // data and address width

  // Arbiter FSM encodings.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // A word access touches addr and addr+1, so the last legal start
  // address is depth-2.
  function automatic logic out_of_range(input logic [WORD_WIDTH-1:0] addr,
                                        input int depth);
    return {16'b0, addr} > $unsigned(depth - 2);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the memory and the arbiter.
// slave = the arbiter side, master = requesters plus memory side.
interface mem_arbiter_if #(
  parameter int WORD_WIDTH = mem_arbiter_pkg::WORD_WIDTH
);

  // Port 0 (instruction fetch)
  logic                  req0;
  logic                  we0;
  logic [WORD_WIDTH-1:0] addr0;
  logic [WORD_WIDTH-1:0] wdata0;
  logic                  ack0;

  // Port 1 (load/store)
  logic                  req1;
  logic                  we1;
  logic [WORD_WIDTH-1:0] addr1;
  logic [WORD_WIDTH-1:0] wdata1;
  logic                  ack1;

  // Shared response
  logic [WORD_WIDTH-1:0] rdata;
  logic                  err;
  logic                  busy;

  // Memory side
  logic [WORD_WIDTH-1:0] mem_address;
  logic                  mem_wr_en;
  logic [WORD_WIDTH-1:0] mem_data_in;
  logic [WORD_WIDTH-1:0] mem_data_out;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_data_out,
    output ack0, ack1, rdata, err, busy,
    output mem_address, mem_wr_en, mem_data_in
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_data_out,
    input  ack0, ack1, rdata, err, busy,
    input  mem_address, mem_wr_en, mem_data_in
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker: a lone request wins outright,
// on a tie the port that did not win last time is chosen.
module mem_arbiter_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_gnt,
  output logic       o_valid
);

  // Pick the winner index; o_gnt is meaningless when o_valid is low.
  always_comb begin
    o_valid = |i_req;
    o_gnt   = 1'b0;
    if (i_req == 2'b11) begin
      o_gnt = ~i_last_grant;
    end else if (i_req[1]) begin
      o_gnt = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: grants req/ack transactions round-robin and
// drives the single memory. Each transaction is IDLE -> ACCESS -> DONE.
module mem_arbiter #(
  parameter int MEM_DEPTH  = mem_arbiter_pkg::MEM_DEPTH,
  parameter int WORD_WIDTH = mem_arbiter_pkg::WORD_WIDTH
) (
  input logic           clock,
  input logic           reset,   // synchronous, active low
  mem_arbiter_if.slave  bus
);

  import mem_arbiter_pkg::*;

  state_e                r_state;
  logic                  r_we_q;
  logic [WORD_WIDTH-1:0] r_addr_q;
  logic [WORD_WIDTH-1:0] r_wdata_q;
  logic                  r_gnt_q;
  logic                  r_err_q;
  logic                  r_last_grant;
  logic                  r_ack0;
  logic                  r_ack1;
  logic [WORD_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  r_busy;
  logic [WORD_WIDTH-1:0] r_mem_address;
  logic [WORD_WIDTH-1:0] r_mem_data_in;

  logic                  w_gnt;
  logic                  w_valid;
  logic                  w_sel_we;
  logic [WORD_WIDTH-1:0] w_sel_addr;
  logic [WORD_WIDTH-1:0] w_sel_wdata;
  logic                  w_mem_wr_en;

  mem_arbiter_rr_arb2 u_rr_arb2 (
    .i_req        ({bus.req1, bus.req0}),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_gnt),
    .o_valid      (w_valid)
  );

  // Steer the winning port's command fields toward the latches.
  always_comb begin
    w_sel_we    = bus.we0;
    w_sel_addr  = bus.addr0;
    w_sel_wdata = bus.wdata0;
    if (w_gnt) begin
      w_sel_we    = bus.we1;
      w_sel_addr  = bus.addr1;
      w_sel_wdata = bus.wdata1;
    end
  end

  // Write strobe only in ACCESS; gating with reset makes a reset edge
  // during ACCESS suppress the commit.
  always_comb begin
    w_mem_wr_en = r_we_q & ~r_err_q & reset & (r_state == ST_ACCESS);
  end

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_we_q        <= 1'b0;
      r_addr_q      <= '0;
      r_wdata_q     <= '0;
      r_gnt_q       <= 1'b0;
      r_err_q       <= 1'b0;
      r_last_grant  <= 1'b1;   // port 0 wins the first tie
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_busy        <= 1'b0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_we_q        <= w_sel_we;
            r_addr_q      <= w_sel_addr;
            r_wdata_q     <= w_sel_wdata;
            r_gnt_q       <= w_gnt;
            r_last_grant  <= w_gnt;
            r_err_q       <= out_of_range(w_sel_addr, MEM_DEPTH);
            r_mem_address <= w_sel_addr;
            r_mem_data_in <= w_sel_wdata;
            r_busy        <= 1'b1;
            r_state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_rdata <= (r_we_q | r_err_q) ? '0 : bus.mem_data_out;
          r_err   <= r_err_q;
          r_ack0  <= ~r_gnt_q;
          r_ack1  <= r_gnt_q;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          // Response visible for this one cycle only; requests ignored.
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack0        = r_ack0;
  assign bus.ack1        = r_ack1;
  assign bus.rdata       = r_rdata;
  assign bus.err         = r_err;
  assign bus.busy        = r_busy;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_data_in = r_mem_data_in;
  assign bus.mem_wr_en   = w_mem_wr_en;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide memory model.
module tb_mem_arbiter;

  logic       clock;
  logic       reset;
  logic       preload;
  logic [7:0] mem [0:2047];
  int         n_checks;
  int         n_errors;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Memory model: big-endian word writes, preload byte i = i[7:0].
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'(i);
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_address[10:0]]          <= bus.mem_data_in[15:8];
      mem[bus.mem_address[10:0] + 11'd1]  <= bus.mem_data_in[7:0];
    end
  end

  // Combinational read; out-of-range returns a poison value.
  always_comb begin
    bus.mem_data_out = 16'hDEAD;
    if (bus.mem_address < 16'd2047)
      bus.mem_data_out = {mem[bus.mem_address[10:0]],
                          mem[bus.mem_address[10:0] + 11'd1]};
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One isolated transaction, starting at a negedge with the FSM idle.
  task automatic txn(input bit port, input bit we, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic [15:0] exp_rdata,
                     input bit exp_err);
    string t;
    t = $sformatf("p%0d we%0d a%h", port, we, addr);
    if (port == 1'b0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end
    @(posedge clock); @(negedge clock);
    chk({t, " busy_access"}, 32'(bus.busy), 32'd1);
    chk({t, " no_early_ack"}, 32'({bus.ack1, bus.ack0}), 32'd0);
    chk({t, " mem_address"}, 32'(bus.mem_address), 32'(addr));
    chk({t, " mem_wr_en"}, 32'(bus.mem_wr_en), 32'(we & ~exp_err));
    @(posedge clock); @(negedge clock);
    chk({t, " ack"}, 32'({bus.ack1, bus.ack0}), port ? 32'd2 : 32'd1);
    chk({t, " rdata"}, 32'(bus.rdata), 32'(exp_rdata));
    chk({t, " err"}, 32'(bus.err), 32'(exp_err));
    $display("txn port=%0d we=%0d addr=%h wdata=%h rdata=%h err=%0d",
             port, we, addr, wdata, bus.rdata, bus.err);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(posedge clock); @(negedge clock);
    chk({t, " back_idle"}, 32'({bus.busy, bus.ack1, bus.ack0}), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clock = 1'b0;
    reset = 1'b0;
    preload = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    @(negedge clock);
    preload = 1'b0;

    // 1: reset held with both requests up, then tie goes to port 0.
    bus.req0 = 1'b1; bus.addr0 = 16'd2;
    bus.req1 = 1'b1; bus.addr1 = 16'd4;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); @(negedge clock);
      chk("reset_acks", 32'({bus.ack1, bus.ack0}), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_wr_en", 32'(bus.mem_wr_en), 32'd0);
      chk("reset_rdata", 32'(bus.rdata), 32'd0);
    end
    reset = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clock); @(negedge clock);
      chk($sformatf("first_tie ack0 c%0d", c), 32'(bus.ack0), 32'(c == 2));
      chk($sformatf("first_tie ack1 c%0d", c), 32'(bus.ack1), 32'(c == 5));
      if (c == 2) begin
        chk("first_tie rdata0", 32'(bus.rdata), 32'h0203);
        $display("txn port=0 we=0 addr=0002 rdata=%h err=%0d", bus.rdata, bus.err);
        bus.req0 = 1'b0;
      end
      if (c == 5) begin
        chk("first_tie rdata1", 32'(bus.rdata), 32'h0405);
        $display("txn port=1 we=0 addr=0004 rdata=%h err=%0d", bus.rdata, bus.err);
        bus.req1 = 1'b0;
      end
    end
    chk("first_tie idle", 32'(bus.busy), 32'd0);

    // 2: plain reads, odd address included.
    txn(1'b0, 1'b0, 16'd2, 16'h0000, 16'h0203, 1'b0);
    txn(1'b0, 1'b0, 16'd1, 16'h0000, 16'h0102, 1'b0);

    // 3: write then read back through the other port.
    txn(1'b1, 1'b1, 16'd2, 16'h000F, 16'h0000, 1'b0);
    txn(1'b0, 1'b0, 16'd2, 16'h0000, 16'h000F, 1'b0);
    chk("byte2", 32'(mem[2]), 32'h00);
    chk("byte3", 32'(mem[3]), 32'h0F);

    // 5: boundary addresses.
    txn(1'b1, 1'b1, 16'd2047, 16'hBEEF, 16'h0000, 1'b1);
    txn(1'b1, 1'b0, 16'd2046, 16'h0000, 16'hFEFF, 1'b0);
    txn(1'b1, 1'b0, 16'd2047, 16'h0000, 16'h0000, 1'b1);
    chk("byte2047", 32'(mem[2047]), 32'hFF);

    // 4: both held; last grant was port 1 so order is 0,1,0,1.
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'd0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'd4;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clock); @(negedge clock);
      chk($sformatf("alt ack0 c%0d", c), 32'(bus.ack0), 32'(c == 2 || c == 8));
      chk($sformatf("alt ack1 c%0d", c), 32'(bus.ack1), 32'(c == 5 || c == 11));
      if (bus.ack0 || bus.ack1)
        $display("txn port=%0d we=0 rdata=%h err=%0d", bus.ack1, bus.rdata, bus.err);
      if (c == 2 || c == 8) chk("alt rdata0", 32'(bus.rdata), 32'h0001);
      if (c == 5 || c == 11) chk("alt rdata1", 32'(bus.rdata), 32'h0405);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("alt idle", 32'(bus.busy), 32'd0);

    // 6: reset pulled low during ACCESS of a write.
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'd4; bus.wdata0 = 16'hAAAA;
    @(posedge clock); @(negedge clock);
    chk("abort busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    #1;
    chk("abort wr_en", 32'(bus.mem_wr_en), 32'd0);
    @(posedge clock); @(negedge clock);
    chk("abort acks", 32'({bus.ack1, bus.ack0}), 32'd0);
    chk("abort busy_after", 32'(bus.busy), 32'd0);
    $display("txn port=0 we=1 addr=0004 aborted by reset");
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    chk("abort no_late_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
    txn(1'b0, 1'b0, 16'd4, 16'h0000, 16'h0405, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
